// File: rtl/pulse_seq_gen.sv
// Triggered pulse-burst generator: emits `burst` pulses of hi_len cycles high / lo_len cycles low.
// Optional cancel input `abort` is compiled in when PULSE_SEQ_ABORT_EN is defined.
module pulse_seq_gen #(
    parameter int LEN_W = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             x_in,
    input  logic [LEN_W-1:0] hi_len,
    input  logic [LEN_W-1:0] lo_len,
    input  logic [CNT_W-1:0] burst,
`ifdef PULSE_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             y_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] hi_cap_q, hi_cap_d;
    logic [LEN_W-1:0] lo_cap_q, lo_cap_d;
    logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
    logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic             y_out_q, y_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Zero-valued lengths are clamped once at capture so the counters never start at 0.
    function automatic logic [LEN_W-1:0] len_at_least_one(input logic [LEN_W-1:0] v);
        return (v == '0) ? LEN_W'(1) : v;
    endfunction

    always_comb begin
        state_d     = state_q;
        hi_cap_d    = hi_cap_q;
        lo_cap_d    = lo_cap_q;
        len_cnt_d   = len_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        y_out_d     = y_out_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (x_in) begin
                    hi_cap_d    = len_at_least_one(hi_len);
                    lo_cap_d    = len_at_least_one(lo_len);
                    len_cnt_d   = len_at_least_one(hi_len);
                    pulse_cnt_d = (burst == '0) ? CNT_W'(1) : burst;
                    state_d     = HIGH;
                    y_out_d     = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            HIGH: begin
                if (len_cnt_q <= LEN_W'(1)) begin
                    len_cnt_d = lo_cap_q;
                    state_d   = LOW;
                    y_out_d   = 1'b0;
                end else begin
                    len_cnt_d = len_cnt_q - LEN_W'(1);
                end
            end
            LOW: begin
                if (len_cnt_q <= LEN_W'(1)) begin
                    if (pulse_cnt_q <= CNT_W'(1)) begin
                        len_cnt_d   = '0;
                        pulse_cnt_d = '0;
                        state_d     = IDLE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        pulse_cnt_d = pulse_cnt_q - CNT_W'(1);
                        len_cnt_d   = hi_cap_q;
                        state_d     = HIGH;
                        y_out_d     = 1'b1;
                    end
                end else begin
                    len_cnt_d = len_cnt_q - LEN_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                y_out_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

`ifdef PULSE_SEQ_ABORT_EN
        // Abort outranks everything, including a start request while idle.
        if (abort) begin
            len_cnt_d   = '0;
            pulse_cnt_d = '0;
            state_d     = IDLE;
            y_out_d     = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q     <= IDLE;
            hi_cap_q    <= '0;
            lo_cap_q    <= '0;
            len_cnt_q   <= '0;
            pulse_cnt_q <= '0;
            y_out_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_cap_q    <= hi_cap_d;
            lo_cap_q    <= lo_cap_d;
            len_cnt_q   <= len_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            y_out_q     <= y_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign y_out = y_out_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
